// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard detection unit.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         CNT_W    = 4;

  // The wait counter is CNT_W bits wide, so latencies above 15 cannot be tracked.
  function automatic bit mem_latency_ok(input int lat);
    return (lat >= 1) && (lat <= 15);
  endfunction

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating event counter: counts cycles with en=1 and holds at all-ones.
module stall_perf_counter #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic [STALL_CNT_W-1:0] count
);

  localparam logic [STALL_CNT_W-1:0] SAT = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  // Count enabled cycles until the counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != SAT)) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use, taken-branch and multi-cycle memory hazard control for PC, IF/ID,
// ID/EX and the downstream pipeline registers, plus a lost-fetch-cycle counter.
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_ex_MemRead,
  input  logic [4:0]             id_ex_write_reg,
  input  logic [4:0]             if_id_read_reg_1,
  input  logic [4:0]             if_id_read_reg_2,
  input  logic                   if_id_uses_rs,
  input  logic                   if_id_uses_rt,
  input  logic                   id_ex_branch_taken,
  input  logic                   ex_mem_MemRead,
  input  logic                   ex_mem_MemWrite,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   pipe_freeze,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  if (!mem_latency_ok(MEM_LATENCY)) begin : g_bad_latency
    $error("hazard_detection_unit: MEM_LATENCY must be within 1..15");
  end

  localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(MEM_LATENCY - 1);
  localparam logic             MULTI_CYCLE = (MEM_LATENCY > 1) ? 1'b1 : 1'b0;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             mem_acc;
  logic             freeze;
  logic             rs_match;
  logic             rt_match;
  logic             load_use;

  assign mem_acc  = ex_mem_MemRead | ex_mem_MemWrite;
  assign rs_match = if_id_uses_rs & (if_id_read_reg_1 == id_ex_write_reg);
  assign rt_match = if_id_uses_rt & (if_id_read_reg_2 == id_ex_write_reg);
  assign load_use = id_ex_MemRead & (id_ex_write_reg != REG_ZERO) & (rs_match | rt_match);

  // Memory-wait sequencing; the release cycle ignores mem_acc because the
  // finishing access is still visible in EX/MEM.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    freeze     = 1'b0;
    case (state)
      RUN: begin
        if (mem_acc && MULTI_CYCLE) begin
          freeze     = 1'b1;
          cnt_next   = WAIT_LOAD;
          state_next = MEM_WAIT;
        end else begin
          state_next = RUN;
        end
      end
      MEM_WAIT: begin
        if (cnt > 4'd1) begin
          freeze   = 1'b1;
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = RUN;
          cnt_next   = 4'd0;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Prioritised control actions: reset, freeze, branch, load-use, run.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (id_ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      pc_write = 1'b1;
    end
  end

  // Wait-FSM state and countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  stall_perf_counter #(
    .STALL_CNT_W(STALL_CNT_W)
  ) u_stall_perf_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (~pc_write),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_hazard_detection_unit;

  localparam int LAT = 3;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          id_ex_MemRead;
  logic [4:0]    id_ex_write_reg;
  logic [4:0]    if_id_read_reg_1;
  logic [4:0]    if_id_read_reg_2;
  logic          if_id_uses_rs;
  logic          if_id_uses_rt;
  logic          id_ex_branch_taken;
  logic          ex_mem_MemRead;
  logic          ex_mem_MemWrite;
  logic          pc_write;
  logic          if_id_write;
  logic          if_id_flush;
  logic          id_ex_bubble;
  logic          pipe_freeze;
  logic [CW-1:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  hazard_detection_unit #(
    .MEM_LATENCY(LAT),
    .STALL_CNT_W(CW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_ex_MemRead     (id_ex_MemRead),
    .id_ex_write_reg   (id_ex_write_reg),
    .if_id_read_reg_1  (if_id_read_reg_1),
    .if_id_read_reg_2  (if_id_read_reg_2),
    .if_id_uses_rs     (if_id_uses_rs),
    .if_id_uses_rt     (if_id_uses_rt),
    .id_ex_branch_taken(id_ex_branch_taken),
    .ex_mem_MemRead    (ex_mem_MemRead),
    .ex_mem_MemWrite   (ex_mem_MemWrite),
    .pc_write          (pc_write),
    .if_id_write       (if_id_write),
    .if_id_flush       (if_id_flush),
    .id_ex_bubble      (id_ex_bubble),
    .pipe_freeze       (pipe_freeze),
    .stall_cycles      (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an access accepted at cycle acc_start freezes cycles of age 0..LAT-2
  // and is gone after age LAT-1; stalls counts pc_write=0 cycles, saturating.
  int cyc;
  int acc_start;
  int stalls;
  bit m_fz, m_lu;
  bit exp_pc, exp_ifid, exp_flush, exp_bub, exp_fz;

  always_comb begin
    m_lu = id_ex_MemRead && (id_ex_write_reg != 5'd0) &&
           ((if_id_uses_rs && if_id_read_reg_1 == id_ex_write_reg) ||
            (if_id_uses_rt && if_id_read_reg_2 == id_ex_write_reg));
    if (acc_start >= 0) m_fz = (cyc - acc_start) < (LAT - 1);
    else                m_fz = (ex_mem_MemRead || ex_mem_MemWrite) && (LAT > 1);
    exp_pc = 1'b1; exp_ifid = 1'b1; exp_flush = 1'b0; exp_bub = 1'b0; exp_fz = 1'b0;
    if (!rst_n) begin
      exp_pc = 1'b0; exp_ifid = 1'b0; exp_fz = 1'b1;
    end else if (m_fz) begin
      exp_pc = 1'b0; exp_ifid = 1'b0; exp_fz = 1'b1;
    end else if (id_ex_branch_taken) begin
      exp_flush = 1'b1; exp_bub = 1'b1;
    end else if (m_lu) begin
      exp_pc = 1'b0; exp_ifid = 1'b0; exp_bub = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0; acc_start <= -1; stalls <= 0;
    end else begin
      if (acc_start >= 0) begin
        if (cyc - acc_start >= LAT - 1) acc_start <= -1;
      end else if ((ex_mem_MemRead || ex_mem_MemWrite) && LAT > 1) begin
        acc_start <= cyc;
      end
      if (!exp_pc && stalls < SAT) stalls <= stalls + 1;
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cmp_pc_write", 32'(pc_write), 32'(exp_pc));
    chk("cmp_if_id_write", 32'(if_id_write), 32'(exp_ifid));
    chk("cmp_if_id_flush", 32'(if_id_flush), 32'(exp_flush));
    chk("cmp_id_ex_bubble", 32'(id_ex_bubble), 32'(exp_bub));
    chk("cmp_pipe_freeze", 32'(pipe_freeze), 32'(exp_fz));
    chk("cmp_stall_cycles", 32'(stall_cycles), 32'(stalls));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_ex_MemRead = 1'b0; id_ex_write_reg = 5'd0;
    if_id_read_reg_1 = 5'd0; if_id_read_reg_2 = 5'd0;
    if_id_uses_rs = 1'b0; if_id_uses_rt = 1'b0;
    id_ex_branch_taken = 1'b0; ex_mem_MemRead = 1'b0; ex_mem_MemWrite = 1'b0;
  endtask

  task automatic rand_inputs();
    id_ex_MemRead      = ($urandom_range(0, 1) == 1);
    id_ex_write_reg    = 5'($urandom_range(0, 3));
    if_id_read_reg_1   = 5'($urandom_range(0, 3));
    if_id_read_reg_2   = 5'($urandom_range(0, 3));
    if_id_uses_rs      = ($urandom_range(0, 1) == 1);
    if_id_uses_rt      = ($urandom_range(0, 1) == 1);
    id_ex_branch_taken = ($urandom_range(0, 4) == 0);
    ex_mem_MemRead     = ($urandom_range(0, 5) == 0);
    ex_mem_MemWrite    = ($urandom_range(0, 5) == 0);
  endtask

  task automatic load_use_rt8();
    id_ex_MemRead = 1'b1; id_ex_write_reg = 5'd8;
    if_id_read_reg_2 = 5'd8; if_id_uses_rt = 1'b1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    // Reset holds outputs regardless of inputs.
    for (int i = 0; i < 3; i++) begin
      tick();
      rand_inputs();
      #2;
      chk("rst_pc_write", 32'(pc_write), 32'd0);
      chk("rst_if_id_write", 32'(if_id_write), 32'd0);
      chk("rst_pipe_freeze", 32'(pipe_freeze), 32'd1);
      chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
    end
    tick();
    rst_n = 1'b1;
    idle();
    #2;
    chk("rel_pc_write", 32'(pc_write), 32'd1);
    chk("rel_if_id_write", 32'(if_id_write), 32'd1);
    chk("rel_controls", 32'({if_id_flush, id_ex_bubble, pipe_freeze}), 32'd0);

    // Load-use stall, then the $0 and uses_rt=0 non-hazards.
    tick(); load_use_rt8(); #2;
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
    tick(); idle(); #2;
    chk("lu_stall_cycles", 32'(stall_cycles), 32'd1);
    chk("lu_clear_pc_write", 32'(pc_write), 32'd1);
    tick(); load_use_rt8(); id_ex_write_reg = 5'd0; if_id_read_reg_2 = 5'd0; #2;
    chk("lu_reg0_pc_write", 32'(pc_write), 32'd1);
    tick(); load_use_rt8(); if_id_uses_rt = 1'b0; #2;
    chk("lu_nort_pc_write", 32'(pc_write), 32'd1);

    // Branch beats load-use.
    tick(); load_use_rt8(); id_ex_branch_taken = 1'b1; #2;
    chk("br_flush", 32'(if_id_flush), 32'd1);
    chk("br_bubble", 32'(id_ex_bubble), 32'd1);
    chk("br_pc_write", 32'(pc_write), 32'd1);
    tick(); idle(); #2;
    chk("br_stall_cycles", 32'(stall_cycles), 32'd1);

    // Single store: two freeze cycles then release.
    tick(); pulse_reset();
    tick(); ex_mem_MemWrite = 1'b1; #2; chk("mw_freeze0", 32'(pipe_freeze), 32'd1);
    tick(); #2; chk("mw_freeze1", 32'(pipe_freeze), 32'd1);
    tick(); #2; chk("mw_release", 32'(pipe_freeze), 32'd0);
    chk("mw_release_pc", 32'(pc_write), 32'd1);
    tick(); idle(); #2; chk("mw_stall_cycles", 32'(stall_cycles), 32'd2);

    // Back-to-back accesses: 1,1,0,1,1,0 freeze pattern.
    tick(); pulse_reset();
    for (int i = 0; i < 6; i++) begin
      tick(); ex_mem_MemWrite = 1'b1; #2;
      chk("b2b_freeze", 32'(pipe_freeze), (i % 3 == 2) ? 32'd0 : 32'd1);
    end
    tick(); idle(); #2;
    chk("b2b_stall_cycles", 32'(stall_cycles), 32'd4);

    // Freeze dominates branch and load-use; branch acts on release.
    tick(); pulse_reset();
    for (int i = 0; i < 3; i++) begin
      tick(); ex_mem_MemRead = 1'b1; id_ex_branch_taken = 1'b1; load_use_rt8(); #2;
      chk("fd_freeze", 32'(pipe_freeze), (i == 2) ? 32'd0 : 32'd1);
      chk("fd_flush", 32'(if_id_flush), (i == 2) ? 32'd1 : 32'd0);
      chk("fd_bubble", 32'(id_ex_bubble), (i == 2) ? 32'd1 : 32'd0);
    end

    // Saturation over 20 stall cycles.
    tick(); pulse_reset();
    for (int i = 0; i < 20; i++) begin
      tick(); load_use_rt8();
    end
    tick(); idle(); #2;
    chk("sat_stall_cycles", 32'(stall_cycles), 32'd15);

    // Asynchronous reset while in MEM_WAIT with cnt=2.
    tick(); ex_mem_MemWrite = 1'b1;
    tick(); #1;
    chk("mid_in_wait", 32'(pipe_freeze), 32'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_stall", 32'(stall_cycles), 32'd0);
    chk("mid_rst_freeze", 32'(pipe_freeze), 32'd1);
    rst_n = 1'b1; idle(); #1;
    chk("mid_run_freeze", 32'(pipe_freeze), 32'd0);
    chk("mid_run_pc", 32'(pc_write), 32'd1);

    // Randomized phase against the model with occasional resets.
    for (int i = 0; i < 400; i++) begin
      tick();
      rand_inputs();
      if (rst_n == 1'b0) rst_n = 1'b1;
      else if ($urandom_range(0, 49) == 0) rst_n = 1'b0;
    end
    tick();
    rst_n = 1'b1;
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
